ibis_vga_timing_recover: RTL
============================

# ibis_vga_timing_recover

Sink-side timing recovery for the Ibis video path. It takes a raw hsync/vsync/data_enable stream, whether from the Ibis timing generator or an external source, and rebuilds per-pixel active coordinates. It also measures line and frame geometry and asserts `locked` once the geometry has been stable for a set number of frames. It sits in front of capture and scaler logic that needs coordinates but only receives sync signals.

## Interface
- `WIDTH`, 10: width of all coordinate and measurement counters.
- `LOCK_FRAMES`, 2: number of consecutive matching frames required before `locked` asserts (1..15).
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `enable` in 1: pixel strobe. All state advances only on cycles with `enable`=1.
- `hsync_in` in 1: horizontal sync, negative polarity.
- `vsync_in` in 1: vertical sync, negative polarity.
- `de_in` in 1: data enable, active high.
- `pixel_valid` out 1: the current recovered pixel is active.
- `ord_x` out WIDTH: active-pixel x, 0 at the first DE pixel of each line.
- `ord_y` out WIDTH: active-line y, 0 at the first DE line after vsync.
- `sof` out 1: one-strobe flag, set with the pixel where `ord_x`=0 and `ord_y`=0.
- `h_total`, `h_active`, `v_total`, `v_active` out WIDTH each: published geometry.
- `locked` out 1: geometry is stable.
- `mismatch` out 1: one-aclk pulse when a committed frame differs from the published geometry.

## Operation
- **Stage 1, on each enable strobe:**
  - Sample the inputs into `s_h`, `s_v`, `s_de`.
  - Copy the previous samples into `p_h`, `p_v`, `p_de`.
  - Derive events: `hs_fall` = `p_h`&~`s_h`, `vs_fall` = `p_v`&~`s_v`, `de_rise` = ~`p_de`&`s_de`, `de_fall` = `p_de`&~`s_de`.
- **X tracking:**
  - On `de_rise`, x is set to 0.
  - Otherwise, while `s_de` is high, x increments.
  - `pixel_valid` is set to `s_de`.
- **Y tracking:**
  - `vs_fall` sets a `new_frame` flag.
  - On `de_rise` with the flag set, y is set to 0 and the flag clears.
  - On `de_rise` without the flag, y increments.
- **h_total measurement:**
  - The line counter is set to 1 on `hs_fall`; otherwise it increments.
  - On `hs_fall`, the counter value is captured.
  - If that capture differs from the previous line's capture within the same frame, the frame is marked dirty.
- **h_active measurement:** on `de_fall`, capture x+1.
- **v_total measurement:**
  - Count `hs_fall` events between consecutive `vs_fall` events.
  - If `hs_fall` and `vs_fall` occur on the same strobe, that line belongs to the new frame: capture the old count, then set the count to 1.
- **v_active measurement:** at `vs_fall`, capture y+1, or 0 if no `de_rise` occurred in the frame.
- **Saturation:** every counter saturates at all-ones. Saturation marks the frame dirty.
- **Frame commit, at each `vs_fall` except the first after reset** (the first only arms measurement):
  - If the frame is clean and all four captures equal the published outputs, the match count increments, saturating at `LOCK_FRAMES`.
  - Otherwise, the captures are published, the match count goes to 0, `locked` goes to 0, and `mismatch` pulses.
  - `locked` is set to 1 when the match count equals `LOCK_FRAMES`.
  - The dirty flag clears at every commit.
- **Loss of signal:** if the v_total counter saturates, `locked` drops immediately.

## Timing
- **Latency:** an input present at strobe k is reflected on `pixel_valid`, `ord_x`, `ord_y` and `sof` after strobe k+1, i.e. a two-strobe pipeline.
- **Commit timing:** geometry outputs, `locked` and `mismatch` update on the aclk edge of the commit strobe. `mismatch` is high for exactly one aclk cycle.
- **Held outputs:** between enable strobes, all outputs hold.
- **Reset values:** `pixel_valid`=0, `sof`=0, `ord_x`=0, `ord_y`=0, all geometry outputs=0, `locked`=0, `mismatch`=0, match count=0.
- **Sample registers at reset:** `s_*`/`p_*` reset to h=1, v=1, de=0, so no spurious events fire on the first strobe.
- **Reset mid-frame:** all state is discarded. The next `vs_fall` only arms measurement, so `locked` takes at least `LOCK_FRAMES`+1 complete frames to assert.

## Configuration
- `IBIS_VGA_RECOVER_ERRCNT_EN`: adds output `err_count` [15:0].
  - Counts `mismatch` pulses, saturating at 16'hFFFF.
  - Resets to 0 on `aresetn`.
  - Without the macro, the port and its counter are absent and behaviour is otherwise identical.

## Test plan
- **Generator loopback, 640x480@60, enable every 5th aclk:**
  - After 3 frames, `locked`=1 and h_total/h_active/v_total/v_active read 800/640/525/480.
  - `mismatch` pulses exactly once (first commit).
- **Coordinate check:**
  - First DE pixel of the frame gives `ord_x`=0, `ord_y`=0, `sof`=1, two strobes after `de_in` rises.
  - Last active pixel reads `ord_x`=639, `ord_y`=479.
- **Geometry change:** switch the line length to 801 mid-stream.
  - The frame is dirty, `locked`=0 at the next commit, and h_total reads 801.
  - `locked` reasserts `LOCK_FRAMES` frames later.
- **Loss of vsync:** hold `vsync_in` high.
  - The v_total counter saturates at 1023 lines and `locked` drops.
  - `ord_y` keeps counting until it saturates at 1023.
- **Coincident events:** `hs_fall` and `vs_fall` on the same strobe → v_total still 525 on the following commit.
- **Reset mid-frame:** all outputs return to their reset values the next cycle; relock requires 3 full frames.

Source files
------------

// File: rtl/ibis_vga_timing_recover.sv
// ibis_vga_timing_recover: rebuilds active-pixel coordinates from hsync/vsync/de and locks onto stable line/frame geometry.
// Optional feature: define IBIS_VGA_RECOVER_ERRCNT_EN to add err_count, a saturating count of mismatch pulses.
module ibis_vga_timing_recover #(
  parameter int WIDTH       = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic             pixel_valid,
  output logic [WIDTH-1:0] ord_x,
  output logic [WIDTH-1:0] ord_y,
  output logic             sof,
  output logic [WIDTH-1:0] h_total,
  output logic [WIDTH-1:0] h_active,
  output logic [WIDTH-1:0] v_total,
  output logic [WIDTH-1:0] v_active,
  output logic             locked,
  output logic             mismatch
`ifdef IBIS_VGA_RECOVER_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);
  localparam logic [3:0] lock_n = 4'(LOCK_FRAMES);
  logic s_h, s_v, s_de, p_h, p_v, p_de;
  logic hs_fall, vs_fall, de_rise, de_fall, nf;
  logic new_frame, frame_de, h_seen, dirty, armed;
  logic commit, same, good, lost, sat;
  logic [WIDTH-1:0] x_nxt, vcnt_nxt, va_val, hcnt, vcnt, h_cap, a_cap;
  logic [3:0] mcnt, mcnt_inc;

  function automatic logic [WIDTH-1:0] inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Edge events from the two sample stages and the next-state values they select.
  always_comb begin
    hs_fall  = p_h & ~s_h;
    vs_fall  = p_v & ~s_v;
    de_rise  = ~p_de & s_de;
    de_fall  = p_de & ~s_de;
    nf       = new_frame | vs_fall;
    x_nxt    = de_rise ? '0 : s_de ? inc(ord_x) : ord_x;
    vcnt_nxt = vs_fall ? WIDTH'(hs_fall) : hs_fall ? inc(vcnt) : vcnt;
    va_val   = frame_de ? inc(ord_y) : '0;
    sat      = (s_de & ~de_rise & (&ord_x)) | (de_rise & ~nf & (&ord_y)) |
               (~hs_fall & (&hcnt)) | (hs_fall & ~vs_fall & (&vcnt));
    commit   = vs_fall & armed;
    same     = (h_cap == h_total) && (a_cap == h_active) && (vcnt == v_total) && (va_val == v_active);
    good     = ~dirty & same;
    mcnt_inc = (mcnt == lock_n) ? mcnt : mcnt + 4'd1;
    lost     = &vcnt_nxt;
  end

  // Sampling, coordinate tracking, geometry measurement and frame commit, all gated by the pixel strobe.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      {s_h, s_v, s_de} <= 3'b110;
      {p_h, p_v, p_de} <= 3'b110;
      pixel_valid <= 1'b0;
      ord_x       <= '0;
      ord_y       <= '0;
      sof         <= 1'b0;
      new_frame   <= 1'b0;
      frame_de    <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      h_cap       <= '0;
      a_cap       <= '0;
      h_seen      <= 1'b0;
      dirty       <= 1'b0;
      armed       <= 1'b0;
      mcnt        <= '0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (enable) begin
        {s_h, s_v, s_de} <= {hsync_in, vsync_in, de_in};
        {p_h, p_v, p_de} <= {s_h, s_v, s_de};
        pixel_valid <= s_de;
        ord_x       <= x_nxt;
        sof         <= de_rise & nf;
        if (de_rise) ord_y <= nf ? '0 : inc(ord_y);
        new_frame   <= nf & ~de_rise;
        frame_de    <= de_rise | (frame_de & ~vs_fall);
        hcnt        <= hs_fall ? WIDTH'(1) : inc(hcnt);
        if (hs_fall) h_cap <= hcnt;
        h_seen      <= ~vs_fall & (h_seen | hs_fall);
        if (de_fall) a_cap <= inc(ord_x);
        vcnt        <= vcnt_nxt;
        dirty       <= ~vs_fall & (dirty | sat | (hs_fall & h_seen & (hcnt != h_cap)));
        armed       <= armed | vs_fall;
        if (commit) begin
          mcnt     <= good ? mcnt_inc : '0;
          locked   <= good & (mcnt_inc == lock_n);
          mismatch <= ~good;
          if (!good) begin
            h_total  <= h_cap;
            h_active <= a_cap;
            v_total  <= vcnt;
            v_active <= va_val;
          end
        end
        if (lost) locked <= 1'b0;
      end
    end
  end

`ifdef IBIS_VGA_RECOVER_ERRCNT_EN
  // Count frames whose geometry had to be republished, sticking at full scale.
  always_ff @(posedge aclk) begin
    if (!aresetn) err_count <= '0;
    else if (enable && commit && !good && !(&err_count)) err_count <= err_count + 16'd1;
  end
`endif
endmodule
